// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory test path: bus widths, command and pattern encodings.
package rtl_settings_pkg;

    localparam int AMM_ADDR_W = 31;
    localparam int AMM_DATA_W = 128;
    localparam int BURST_W    = 11;

    typedef enum logic [1:0] {
        PAT_FIXED = 2'd0,
        PAT_INCR  = 2'd1,
        PAT_ALT   = 2'd2
    } pattern_mode_t;

    typedef enum logic {
        WRITE_TRANS = 1'b0,
        READ_TRANS  = 1'b1
    } trans_type_t;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        WRITE_S = 2'd1,
        READ_S  = 2'd2
    } trans_state_t;

    // Unsupported pattern codes fall back to the fixed-seed pattern.
    function automatic pattern_mode_t decode_mode(input logic [2:0] raw);
        return (raw > 3'd2) ? PAT_FIXED : pattern_mode_t'(raw[1:0]);
    endfunction

endpackage

// File: rtl/mem_transmitter_data_gen.sv
// Registered write-data pattern generator; the register always holds the current beat,
// so a beat_advance makes the next beat visible on the following cycle.
module data_gen
    import rtl_settings_pkg::*;
#(
    parameter int DATA_W = AMM_DATA_W,
    parameter int BEAT_W = BURST_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  pattern_mode_t     pattern_mode,
    input  logic [7:0]        seed,
    input  logic              beat_start,
    input  logic              beat_advance,
    output logic [DATA_W-1:0] data_o
);

    localparam int NUM_LANES = DATA_W / 8;

    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [NUM_LANES-1:0][7:0]     lane_d, data_q;
    logic [7:0]                    incr_base;

    assign beat_d    = beat_start ? '0 : beat_q + BEAT_W'(1);
    // Incrementing pattern continues byte numbering across beats, modulo 256.
    assign incr_base = 8'(beat_d * NUM_LANES);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_d[k] = (pattern_mode == PAT_INCR)            ? incr_base + 8'(k) :
                           (pattern_mode == PAT_ALT && beat_d[0]) ? ~seed : seed;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q <= '0;
            data_q <= '0;
        end else if (beat_start || beat_advance) begin
            beat_q <= beat_d;
            data_q <= lane_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mem_transmitter.sv
// Turns control-FSM write/read commands into Avalon-MM bursts and tracks outstanding
// read beats so control can see when the memory path has drained.
module mem_transmitter #(
    parameter int ADDR_W  = rtl_settings_pkg::AMM_ADDR_W,
    parameter int DATA_W  = rtl_settings_pkg::AMM_DATA_W,
    parameter int BURST_W = rtl_settings_pkg::BURST_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_test_i,
    input  logic [2:1][31:0]    test_param_i,
    input  logic                trans_valid_i,
    input  logic                trans_type_i,
    input  logic [ADDR_W-1:0]   trans_addr_i,
    output logic                trans_process_o,
    output logic                trans_busy_o,
    output logic [ADDR_W-1:0]   amm_address_o,
    output logic [BURST_W-1:0]  amm_burstcount_o,
    output logic                amm_write_o,
    output logic [DATA_W-1:0]   amm_writedata_o,
    output logic                amm_read_o,
    input  logic                amm_waitrequest_i,
    input  logic                amm_readdatavalid_i
);

    import rtl_settings_pkg::*;

    localparam int CNT_W = BURST_W + 4;
    localparam logic [CNT_W:0] CNT_LIMIT = {1'b1, {CNT_W{1'b0}}};

    trans_state_t        state_q, state_d;
    logic [BURST_W-1:0]  burst_len_q, burst_q, beats_q, param_len;
    pattern_mode_t       mode_q;
    logic [7:0]          seed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    out_q, out_d;
    logic                process_q, busy_q;
    logic                accept, wr_hs, rd_hs, rd_room, param_ld;
    logic                unused_param;

    assign unused_param = ^{test_param_i[1][31:14], test_param_i[2][31:8]};
    assign param_len    = BURST_W'(test_param_i[1][10:0]);
    assign param_ld     = start_test_i && state_q == IDLE_S && !process_q;

    assign accept  = trans_valid_i && !process_q && state_q == IDLE_S;
    assign wr_hs   = amm_write_o && !amm_waitrequest_i;
    assign rd_hs   = amm_read_o && !amm_waitrequest_i;
    // Only room can appear while waiting, so a raised read never has to be withdrawn.
    assign rd_room = ({1'b0, out_q} + {{(CNT_W+1-BURST_W){1'b0}}, burst_q}) < CNT_LIMIT;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE_S;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_S:  if (accept)
                         state_d = (trans_type_t'(trans_type_i) == READ_TRANS) ? READ_S : WRITE_S;
            WRITE_S: if (wr_hs && beats_q == BURST_W'(1)) state_d = IDLE_S;
            READ_S:  if (rd_hs) state_d = IDLE_S;
            default: state_d = IDLE_S;
        endcase
    end

    always_comb begin
        amm_write_o = 1'b0;
        amm_read_o  = 1'b0;
        unique case (state_q)
            WRITE_S: amm_write_o = 1'b1;
            READ_S:  amm_read_o  = rd_room;
            default: ;
        endcase
    end

    // Beats are booked when the slave takes the read; stray beats with nothing booked are dropped.
    always_comb begin
        out_d = out_q;
        if (rd_hs)
            out_d = out_d + {4'd0, burst_q};
        if (amm_readdatavalid_i && out_d != '0)
            out_d = out_d - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_len_q <= BURST_W'(1);
            mode_q      <= PAT_FIXED;
            seed_q      <= '0;
            addr_q      <= '0;
            burst_q     <= '0;
            beats_q     <= '0;
            out_q       <= '0;
            process_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (param_ld) begin
                burst_len_q <= (param_len == '0) ? BURST_W'(1) : param_len;
                mode_q      <= decode_mode(test_param_i[1][13:11]);
                seed_q      <= test_param_i[2][7:0];
            end
            if (accept) begin
                addr_q  <= trans_addr_i;
                burst_q <= burst_len_q;
                beats_q <= burst_len_q;
            end else if (wr_hs) begin
                beats_q <= beats_q - BURST_W'(1);
            end
            // Held one cycle past the last handshake: that is the bubble between commands.
            if (accept)               process_q <= 1'b1;
            else if (state_q == IDLE_S) process_q <= 1'b0;
            out_q  <= out_d;
            busy_q <= (state_d != IDLE_S) || (out_d != '0);
        end
    end

    data_gen #(
        .DATA_W (DATA_W),
        .BEAT_W (BURST_W)
    ) u_data_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pattern_mode (mode_q),
        .seed         (seed_q),
        .beat_start   (accept),
        .beat_advance (wr_hs),
        .data_o       (amm_writedata_o)
    );

    assign trans_process_o  = process_q;
    assign trans_busy_o     = busy_q;
    assign amm_address_o    = addr_q;
    assign amm_burstcount_o = burst_q;

endmodule

// File: tb/tb_mem_transmitter.sv
// Directed + randomized bench: bus monitor collects accepted beats, expected data comes from the pattern rules.
module tb_mem_transmitter;

    logic             clk_i, rst_i;
    logic             start_test_i;
    logic [2:1][31:0] test_param_i;
    logic             trans_valid_i, trans_type_i;
    logic [30:0]      trans_addr_i;
    logic             trans_process_o, trans_busy_o;
    logic [30:0]      amm_address_o;
    logic [10:0]      amm_burstcount_o;
    logic             amm_write_o, amm_read_o;
    logic [127:0]     amm_writedata_o;
    logic             amm_waitrequest_i, amm_readdatavalid_i;

    mem_transmitter dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start_test_i        (start_test_i),
        .test_param_i        (test_param_i),
        .trans_valid_i       (trans_valid_i),
        .trans_type_i        (trans_type_i),
        .trans_addr_i        (trans_addr_i),
        .trans_process_o     (trans_process_o),
        .trans_busy_o        (trans_busy_o),
        .amm_address_o       (amm_address_o),
        .amm_burstcount_o    (amm_burstcount_o),
        .amm_write_o         (amm_write_o),
        .amm_writedata_o     (amm_writedata_o),
        .amm_read_o          (amm_read_o),
        .amm_waitrequest_i   (amm_waitrequest_i),
        .amm_readdatavalid_i (amm_readdatavalid_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [30:0]  a;
        logic [10:0]  bc;
        logic [127:0] d;
    } beat_t;

    beat_t wq[$];
    beat_t rq[$];
    int    vectors = 0, miscompares = 0;
    int    wr_hi = 0, rd_hi = 0;
    int    cur_len, cur_mode;
    logic [7:0] cur_seed;

    logic         stall_prev = 1'b0;
    logic [43:0]  prev_ctl;
    logic [127:0] prev_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pattern straight from the byte rules.
    function automatic logic [127:0] exp_data(input int mode, input logic [7:0] seed, input int b);
        logic [127:0] d = '0;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                1:       d[k*8 +: 8] = 8'((b * 16 + k) % 256);
                2:       d[k*8 +: 8] = (b % 2 == 1) ? ~seed : seed;
                default: d[k*8 +: 8] = seed;
            endcase
        end
        return d;
    endfunction

    // Bus monitor and stall-stability check, mid-cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_ctl", {amm_write_o, amm_read_o, amm_address_o, amm_burstcount_o}, prev_ctl);
                check("stall_data", amm_writedata_o, prev_data);
            end
            if (amm_write_o) wr_hi++;
            if (amm_read_o)  rd_hi++;
            if (amm_write_o && !amm_waitrequest_i)
                wq.push_back('{amm_address_o, amm_burstcount_o, amm_writedata_o});
            if (amm_read_o && !amm_waitrequest_i)
                rq.push_back('{amm_address_o, amm_burstcount_o, '0});
            stall_prev = (amm_write_o || amm_read_o) && amm_waitrequest_i;
            prev_ctl   = {amm_write_o, amm_read_o, amm_address_o, amm_burstcount_o};
            prev_data  = amm_writedata_o;
        end
    end

    task automatic set_params(input int len_raw, input int mode_raw, input logic [7:0] s);
        test_param_i = '0;
        test_param_i[1][10:0]  = 11'(len_raw);
        test_param_i[1][13:11] = 3'(mode_raw);
        test_param_i[2][7:0]   = s;
        start_test_i = 1'b1;
        @(posedge clk_i); #1;
        start_test_i = 1'b0;
        cur_len  = (len_raw == 0) ? 1 : len_raw;
        cur_mode = (mode_raw > 2) ? 0 : mode_raw;
        cur_seed = s;
    endtask

    // wmode: 0 no backpressure, 1 random, 2 stall beat 1 for two cycles (and poke start_test then)
    task automatic issue(input bit rd, input logic [30:0] a, input int wmode,
                         output int acc_wait, output int proc_cyc);
        int  beats = 0, stalls = 0, guard = 0;
        bit  poked = 1'b0;
        wr_hi = 0; rd_hi = 0;
        trans_valid_i = 1'b1; trans_type_i = rd; trans_addr_i = a;
        acc_wait = 0;
        do begin @(posedge clk_i); #1; acc_wait++; end
        while (!trans_process_o && acc_wait < 20);
        trans_valid_i = 1'b0;
        proc_cyc = 0;
        while (trans_process_o && guard < 300) begin
            proc_cyc++; guard++;
            case (wmode)
                1:       amm_waitrequest_i = ($urandom_range(0, 2) == 0);
                2:       amm_waitrequest_i = amm_write_o && beats == 1 && stalls < 2;
                default: amm_waitrequest_i = 1'b0;
            endcase
            if (amm_waitrequest_i) stalls++;
            if ((amm_write_o || amm_read_o) && !amm_waitrequest_i) beats++;
            if (wmode == 2 && stalls == 1 && !poked) begin
                test_param_i[1] = 32'h0000_0007; test_param_i[2] = 32'h0000_00EE;
                start_test_i = 1'b1; poked = 1'b1;
            end else begin
                start_test_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        start_test_i = 1'b0; amm_waitrequest_i = 1'b0;
        check("cmd_completes_in_bound", guard < 300 && acc_wait < 20, 1);
    endtask

    task automatic verify_write(input logic [30:0] a);
        beat_t bt;
        check("wr_beat_count", wq.size(), cur_len);
        for (int b = 0; b < cur_len && wq.size() > 0; b++) begin
            bt = wq.pop_front();
            check("wr_addr", bt.a, a);
            check("wr_burstcount", bt.bc, cur_len);
            check("wr_data", bt.d, exp_data(cur_mode, cur_seed, b));
        end
        wq.delete();
    endtask

    task automatic verify_read(input logic [30:0] a);
        beat_t bt;
        check("rd_req_count", rq.size(), 1);
        if (rq.size() > 0) begin
            bt = rq.pop_front();
            check("rd_addr", bt.a, a);
            check("rd_burstcount", bt.bc, cur_len);
        end
        rq.delete();
    endtask

    // Deliver n read beats (optionally with gaps); busy must hold until the last one lands.
    task automatic drain(input int n, input bit gaps);
        int sent = 0, guard = 0;
        while (sent < n && guard < 2000) begin
            guard++;
            amm_readdatavalid_i = !gaps || ($urandom_range(0, 3) != 0);
            if (amm_readdatavalid_i) begin
                check("busy_before_beat", trans_busy_o, 1);
                sent++;
            end
            @(posedge clk_i); #1;
        end
        amm_readdatavalid_i = 1'b0;
        check("busy_after_drain", trans_busy_o, 0);
    endtask

    initial begin
        int aw, pc, pend, busy_hi;
        logic [30:0] a;
        bit rd;

        rst_i = 1'b1; start_test_i = 1'b0; test_param_i = '0;
        trans_valid_i = 1'b0; trans_type_i = 1'b0; trans_addr_i = '0;
        amm_waitrequest_i = 1'b0; amm_readdatavalid_i = 1'b0;
        #12;
        check("reset_outputs", {trans_process_o, trans_busy_o, amm_write_o, amm_read_o,
                                amm_address_o, amm_burstcount_o}, '0);
        check("reset_wdata", amm_writedata_o, '0);
        @(posedge clk_i); #1; rst_i = 1'b0;

        // Single write, no backpressure
        set_params(4, 0, 8'hA5);
        issue(1'b0, 31'h100, 0, aw, pc);
        check("wr_accept_wait", aw, 1);
        check("wr_process_cycles", pc, 5);
        check("wr_write_cycles", wr_hi, 4);
        check("wr_busy_after", trans_busy_o, 0);
        verify_write(31'h100);

        // Write with backpressure, mid-burst start_test must be ignored
        set_params(3, 2, 8'h55);
        issue(1'b0, 31'h2A0, 2, aw, pc);
        check("bp_write_cycles", wr_hi, 5);
        check("bp_process_cycles", pc, 6);
        verify_write(31'h2A0);
        issue(1'b0, 31'h2B0, 0, aw, pc);
        verify_write(31'h2B0);

        // Read with latency
        set_params(8, 0, 8'h00);
        issue(1'b1, 31'h20, 0, aw, pc);
        check("rd_read_cycles", rd_hi, 1);
        check("rd_process_cycles", pc, 2);
        verify_read(31'h20);
        busy_hi = 0;
        repeat (10) begin
            if (trans_busy_o) busy_hi++;
            @(posedge clk_i); #1;
        end
        check("rd_busy_during_latency", busy_hi, 10);
        drain(8, 1'b0);

        // Interleaved write/read pairs, one bubble between commands
        set_params(1, 1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            a = 31'(32'h200 + i * 4);
            issue(1'b0, a, 0, aw, pc);
            check("pair_wr_bubble", aw, 1);
            verify_write(a);
            issue(1'b1, a, 0, aw, pc);
            check("pair_rd_bubble", aw, 1);
            verify_read(a);
        end
        drain(16, 1'b1);

        // Zero burst length and out-of-range mode
        set_params(0, 5, 8'hC3);
        issue(1'b0, 31'h7FFF_FFF0, 0, aw, pc);
        verify_write(31'h7FFF_FFF0);

        // Reset in the middle of a 4-beat write
        set_params(4, 0, 8'h3C);
        wq.delete();
        trans_valid_i = 1'b1; trans_type_i = 1'b0; trans_addr_i = 31'h40;
        @(posedge clk_i); #1; trans_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("rst_beats_before", wq.size(), 2);
        rst_i = 1'b1; #1;
        check("rst_mid_outputs", {trans_process_o, trans_busy_o, amm_write_o, amm_read_o,
                                  amm_address_o, amm_burstcount_o}, '0);
        check("rst_mid_wdata", amm_writedata_o, '0);
        @(posedge clk_i); #1; rst_i = 1'b0;
        amm_readdatavalid_i = 1'b1;
        @(posedge clk_i); #1; amm_readdatavalid_i = 1'b0;
        check("stray_beat_ignored", trans_busy_o, 0);
        wq.delete();
        set_params(4, 0, 8'h3C);
        issue(1'b0, 31'h44, 0, aw, pc);
        verify_write(31'h44);

        // Randomized commands with random backpressure
        pend = 0;
        for (int i = 0; i < 16; i++) begin
            set_params($urandom_range(0, 6), $urandom_range(0, 7), 8'($urandom));
            rd = 1'($urandom_range(0, 1));
            a  = 31'($urandom);
            issue(rd, a, 1, aw, pc);
            if (rd) begin
                verify_read(a);
                pend += cur_len;
            end else begin
                verify_write(a);
            end
        end
        if (pend > 0) drain(pend, 1'b1);
        check("final_idle", {trans_busy_o, trans_process_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_transmitter.md
Name: mem_transmitter

Overview:
- Executes the single-word write/read commands issued by the test control FSM as Avalon-MM burst master transactions to the memory under test.
- Accepts commands over a valid/process handshake: `trans_valid_i` from control, `trans_process_o` back.
- Generates write data from a test-parameter pattern and tracks outstanding read beats, so control can tell when the memory path is idle via `trans_busy_o`.
- Read data goes straight from the Avalon bus to the compare block; this block only counts it.

Parameters:
- ADDR_W, 31: Avalon word address width; same value as the control path.
- DATA_W, 128: Avalon data width; must be a multiple of 8.
- BURST_W, 11: Avalon burstcount width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_test_i  in  1  test start strobe; latches parameters
- test_param_i  in  [2:1][31:0]  [1][10:0] burst length; [1][13:11] data pattern mode; [2][7:0] pattern seed byte
- trans_valid_i  in  1  command valid
- trans_type_i  in  1  0 = write, 1 = read
- trans_addr_i  in  ADDR_W  burst start address
- trans_process_o  out  1  command in progress; control must not treat `valid` as accepted while high
- trans_busy_o  out  1  transaction in flight or read beats outstanding
- amm_address_o  out  ADDR_W
- amm_burstcount_o  out  BURST_W
- amm_write_o  out  1
- amm_writedata_o  out  DATA_W
- amm_read_o  out  1
- amm_waitrequest_i  in  1
- amm_readdatavalid_i  in  1

Behaviour:
- Reset values: all outputs 0; state IDLE_S; outstanding counter 0.
- Parameter latch: on `start_test_i`, latch `burst_len` = `test_param_i[1][10:0]`, `pattern_mode` and `seed`.
  - `burst_len` 0 is stored as 1.
  - `pattern_mode` values 3..7 are stored as 0.
- Command acceptance: accepted in the cycle where `trans_valid_i && !trans_process_o && state == IDLE_S`. In that cycle, register `trans_addr_i` and `trans_type_i`.
  - `trans_process_o` is high from acceptance+1 until the cycle after the final Avalon handshake.
  - This gives exactly one idle cycle between back-to-back commands.
- FSM states and transitions:
  - IDLE_S: on acceptance, go to WRITE_S if type 0, otherwise READ_S.
  - WRITE_S:
    - `amm_write_o` = 1 from acceptance+1.
    - `amm_address_o` and `amm_burstcount_o` = `burst_len`, both held constant for the whole burst.
    - A beat counter counts down on each cycle with `!amm_waitrequest_i`.
    - After the last beat is accepted: `amm_write_o` drops to 0, go to IDLE_S.
  - READ_S:
    - `amm_read_o` is asserted only when outstanding + `burst_len` < 2^(BURST_W+4).
    - Once asserted, it is held until `!amm_waitrequest_i`, then dropped; go to IDLE_S.
- Outstanding read beats: counter of width BURST_W+4.
  - `+burst_len` on read command accepted; `-1` on `amm_readdatavalid_i`.
  - Both in the same cycle: net `burst_len - 1`.
  - The counter never wraps.
- `trans_busy_o` (registered) = `(next state != IDLE_S) || (next outstanding != 0)`.
- Write data, beat index b (0-based, restarts per command), byte k:
  - Mode 0: every byte = `seed`.
  - Mode 1: byte = `(b*DATA_W/8 + k) mod 256`.
  - Mode 2: beat b even = `seed`; beat b odd = `~seed`, all bytes.
  - `amm_writedata_o` holds its value while `amm_waitrequest_i` is 1.
- Avalon rule: once `amm_read_o`/`amm_write_o` is asserted, it and address/burst/data stay stable until accepted.
  - `trans_valid_i` falling mid-burst (compare error) does not abort: the burst completes and no new command is taken.
- `start_test_i` while not idle: ignored (no parameter update).
- Reset mid-burst: outputs cleared immediately. The counter clears; beats that arrive after reset are ignored.

Decomposition:
- Add to `rtl_settings_pkg`:
  - `pattern_mode_t` enum (PAT_FIXED, PAT_INCR, PAT_ALT).
  - `BURST_W` and `AMM_DATA_W` constants.
  - `trans_type_t` (WRITE_TRANS = 0, READ_TRANS = 1).
- Sub-module `data_gen`: a registered generator for the write-data pattern.
  - Inputs: `pattern_mode`, `seed`, `beat_start`, `beat_advance`.
  - Output: DATA_W data.
  - Zero latency from `beat_advance` to the next beat being valid.

Test Plan:
- Single write: `burst_len` = 4, mode 0, `seed` = 0xA5, addr 0x100, `waitrequest` 0 → `amm_write_o` high 4 cycles, address 0x100, burstcount 4, all data bytes 0xA5; `trans_process_o` high 5 cycles; `busy` low after.
- Write with backpressure: `burst_len` = 3, mode 2, `waitrequest` high on beat 1 for 2 cycles → data/addr stable during stall; beat sequence 0x55.., 0xAA.. (`seed` 0x55), then 0x55..; 3 accepted beats.
- Read with latency: `burst_len` = 8, read addr 0x20, `readdatavalid` 10 cycles later for 8 cycles → `amm_read_o` for 1 cycle, `trans_process_o` drops early, `trans_busy_o` high until the 8th `readdatavalid`.
- Interleave write/read per control WRITE_WORD/READ_WORD, 16 pairs, `burst_len` = 1, mode 1 → 16 writes then reads to same addresses; byte k = k per beat 0; one bubble cycle between commands.
- `burst_len` = 0 parameter → treated as 1 (burstcount output 1).
- Assert `rst_i` mid-write (beat 2 of 4) → all outputs 0 same cycle; after release, a fresh command runs a full 4-beat burst.
